// File: rtl/eleven_bcd_divider_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : eleven_bcd_divider_checker_if
// Brief    : Digit input bundle and result bundle for the divide-by-11 checker.
// Revision : 1.0 - initial release
// ============================================================================
interface eleven_bcd_divider_checker_if;
  logic       in_valid;
  logic       a3, a2, a1, a0;
  logic       b3, b2, b1, b0;
  logic       c3, c2, c1, c0;
  logic       d3, d2, d1, d0;
  logic       out_valid;
  logic       isDivider;
  logic [3:0] remainder;
  logic       bcd_error;

  modport master (
    output in_valid,
    output a3, a2, a1, a0,
    output b3, b2, b1, b0,
    output c3, c2, c1, c0,
    output d3, d2, d1, d0,
    input  out_valid, isDivider, remainder, bcd_error
  );

  modport slave (
    input  in_valid,
    input  a3, a2, a1, a0,
    input  b3, b2, b1, b0,
    input  c3, c2, c1, c0,
    input  d3, d2, d1, d0,
    output out_valid, isDivider, remainder, bcd_error
  );
endinterface
`default_nettype wire

// File: rtl/eleven_bcd_divider_checker.sv
`default_nettype none
// ============================================================================
// Module   : eleven_bcd_divider_checker
// Brief    : Registered mod-11 / divisibility check of a 4-digit packed-BCD value.
// Revision : 1.0 - initial release
// ============================================================================
module eleven_bcd_divider_checker (
  input  wire                           clk,
  input  wire                           rst,
  eleven_bcd_divider_checker_if.slave   bus
);
  localparam logic [6:0] c_BIAS = 7'd33;

  logic [3:0]        w_digitA, w_digitB, w_digitC, w_digitD;
  logic signed [5:0] w_sum;
  logic [6:0]        w_biased, w_red44, w_red22, w_red11;
  logic              w_bcdError;
  logic [3:0]        w_remainder;
  logic              w_isDivider;

  logic              r_outValid;
  logic              r_isDivider;
  logic [3:0]        r_remainder;
  logic              r_bcdError;

  assign w_digitA = {bus.a3, bus.a2, bus.a1, bus.a0};
  assign w_digitB = {bus.b3, bus.b2, bus.b1, bus.b0};
  assign w_digitC = {bus.c3, bus.c2, bus.c1, bus.c0};
  assign w_digitD = {bus.d3, bus.d2, bus.d1, bus.d0};

  assign w_bcdError = (w_digitA > 4'd9) || (w_digitB > 4'd9) ||
                      (w_digitC > 4'd9) || (w_digitD > 4'd9);

  // 10^k mod 11 alternates +1/-1, so the number is congruent to a - b + c - d.
  assign w_sum = $signed({2'b00, w_digitA}) - $signed({2'b00, w_digitB})
               + $signed({2'b00, w_digitC}) - $signed({2'b00, w_digitD});

  // Adding 33 (a multiple of 11) makes the sum non-negative (3..63 even for
  // non-BCD digits); three conditional subtractions then land it in 0..10.
  assign w_biased = {w_sum[5], w_sum} + c_BIAS;
  assign w_red44  = (w_biased >= 7'd44) ? w_biased - 7'd44 : w_biased;
  assign w_red22  = (w_red44  >= 7'd22) ? w_red44  - 7'd22 : w_red44;
  assign w_red11  = (w_red22  >= 7'd11) ? w_red22  - 7'd11 : w_red22;

  assign w_remainder = w_bcdError ? 4'd0 : w_red11[3:0];
  assign w_isDivider = !w_bcdError && (w_red11 == 7'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid  <= 1'b0;
      r_isDivider <= 1'b0;
      r_remainder <= 4'd0;
      r_bcdError  <= 1'b0;
    end else begin
      r_outValid <= bus.in_valid;
      if (bus.in_valid) begin
        r_isDivider <= w_isDivider;
        r_remainder <= w_remainder;
        r_bcdError  <= w_bcdError;
      end
    end
  end

  assign bus.out_valid = r_outValid;
  assign bus.isDivider = r_isDivider;
  assign bus.remainder = r_remainder;
  assign bus.bcd_error = r_bcdError;
endmodule
`default_nettype wire

// File: tb/tb_eleven_bcd_divider_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_eleven_bcd_divider_checker
// Brief    : Self-checking bench; reference model uses plain decimal arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eleven_bcd_divider_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   failCount  = 0;

  logic       expValid = 1'b0;
  logic       expDivider = 1'b0;
  logic [3:0] expRemainder = 4'd0;
  logic       expError = 1'b0;

  eleven_bcd_divider_checker_if bus ();

  eleven_bcd_divider_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkResult(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle, advance the reference model at the edge, compare after it.
  task automatic runCycle(input string tag, input logic r, input logic v,
                          input logic [3:0] d, input logic [3:0] c,
                          input logic [3:0] b, input logic [3:0] a);
    int value;
    @(negedge clk);
    rst = r;
    bus.in_valid = v;
    {bus.a3, bus.a2, bus.a1, bus.a0} = a;
    {bus.b3, bus.b2, bus.b1, bus.b0} = b;
    {bus.c3, bus.c2, bus.c1, bus.c0} = c;
    {bus.d3, bus.d2, bus.d1, bus.d0} = d;
    @(posedge clk);
    if (r) begin
      expValid = 1'b0; expDivider = 1'b0; expRemainder = 4'd0; expError = 1'b0;
    end else begin
      expValid = v;
      if (v) begin
        expError = (a > 9) || (b > 9) || (c > 9) || (d > 9);
        value = d * 1000 + c * 100 + b * 10 + a;
        expRemainder = expError ? 4'd0 : 4'(value % 11);
        expDivider = !expError && (value % 11 == 0);
      end
    end
    #1;
    checkResult({tag, ".out_valid"}, 32'(bus.out_valid), 32'(expValid));
    checkResult({tag, ".isDivider"}, 32'(bus.isDivider), 32'(expDivider));
    checkResult({tag, ".remainder"}, 32'(bus.remainder), 32'(expRemainder));
    checkResult({tag, ".bcd_error"}, 32'(bus.bcd_error), 32'(expError));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    {bus.a3, bus.a2, bus.a1, bus.a0} = 4'd0;
    {bus.b3, bus.b2, bus.b1, bus.b0} = 4'd0;
    {bus.c3, bus.c2, bus.c1, bus.c0} = 4'd0;
    {bus.d3, bus.d2, bus.d1, bus.d0} = 4'd0;

    // Reset held two cycles with in_valid high: reset must win.
    runCycle("reset0", 1'b1, 1'b1, 4'd9, 4'd0, 4'd9, 4'd0);
    runCycle("reset1", 1'b1, 1'b1, 4'd9, 4'd0, 4'd9, 4'd0);
    checkResult("resetFixed.remainder", 32'(bus.remainder), 32'd0);
    checkResult("resetFixed.out_valid", 32'(bus.out_valid), 32'd0);

    runCycle("n0000", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    checkResult("n0000Fixed.isDivider", 32'(bus.isDivider), 32'd1);
    runCycle("idle", 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
    runCycle("n0099", 1'b0, 1'b1, 4'd0, 4'd0, 4'd9, 4'd9);
    runCycle("n0909", 1'b0, 1'b1, 4'd0, 4'd9, 4'd0, 4'd9);
    checkResult("n0909Fixed.remainder", 32'(bus.remainder), 32'd7);
    runCycle("n0011", 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 4'd1);
    runCycle("n9999", 1'b0, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
    runCycle("n9090", 1'b0, 1'b1, 4'd9, 4'd0, 4'd9, 4'd0);
    checkResult("n9090Fixed.remainder", 32'(bus.remainder), 32'd4);
    runCycle("badA", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'hA);
    runCycle("hold", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    runCycle("n0022", 1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 4'd2);
    runCycle("badD", 1'b0, 1'b1, 4'hF, 4'd0, 4'd0, 4'd0);
    runCycle("n9000", 1'b0, 1'b1, 4'd9, 4'd0, 4'd0, 4'd0);

    // Streaming with a mid-stream reset; no stale pulse afterwards.
    runCycle("n0121", 1'b0, 1'b1, 4'd0, 4'd1, 4'd2, 4'd1);
    runCycle("n0122", 1'b0, 1'b1, 4'd0, 4'd1, 4'd2, 4'd2);
    checkResult("n0122Fixed.remainder", 32'(bus.remainder), 32'd1);
    runCycle("n0123", 1'b0, 1'b1, 4'd0, 4'd1, 4'd2, 4'd3);
    checkResult("n0123Fixed.remainder", 32'(bus.remainder), 32'd2);
    runCycle("midRst", 1'b1, 1'b1, 4'd0, 4'd1, 4'd2, 4'd4);
    runCycle("postRst", 1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 4'd5);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] rd, rc, rb, ra;
      logic rv, rr;
      rr = ($urandom_range(0, 29) == 0);
      rv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        rd = 4'($urandom); rc = 4'($urandom); rb = 4'($urandom); ra = 4'($urandom);
      end else begin
        rd = 4'($urandom_range(0, 9)); rc = 4'($urandom_range(0, 9));
        rb = 4'($urandom_range(0, 9)); ra = 4'($urandom_range(0, 9));
      end
      runCycle("random", rr, rv, rd, rc, rb, ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
`default_nettype wire
